// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway: N-way set-associative line store with true-LRU ages,
// valid/dirty-aware hit detection, victim reporting and an invalidate-all walker.
// The tag word is {valid, dirty, address tag}. Lookups are combinational.
module dcache_sram_nway #(
    parameter int WAYS   = 2,
    parameter int SETS   = 16,
    parameter int TAG_W  = 25,
    parameter int LINE_W = 256,
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic              inv_i,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] data_o,
    output logic              hit_o,
    output logic [WAY_W-1:0]  way_o,
    output logic              busy_o
);

    typedef enum logic {IDLE, WALK} state_t;

    logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
    logic [LINE_W-1:0] data_q [SETS][WAYS];
    // age 0 = most recently used, WAYS-1 = least recently used
    logic [WAY_W-1:0]  age_q  [SETS][WAYS];

    state_t            state_q;
    logic              busy_q;
    logic [IDX_W-1:0]  cnt_q;

    logic [WAYS-1:0]   valid;
    logic [WAYS-1:0]   match;
    logic              lk_hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim_way;
    logic [WAY_W-1:0]  tgt_way;
    logic              active;

    // Per-way valid and tag compare for the addressed set; dirty is not compared.
    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            assign valid[gi] = tag_q[addr_i][gi][TAG_W-1];
            assign match[gi] = valid[gi] &&
                               (tag_q[addr_i][gi][TAG_W-3:0] == tag_i[TAG_W-3:0]);
        end
    endgenerate

    // Hit way (lowest matching index) and victim (lowest invalid, else the oldest).
    always_comb begin
        lk_hit     = 1'b0;
        hit_way    = '0;
        victim_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                lk_hit  = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (age_q[addr_i][w] == WAY_W'(WAYS - 1)) begin
                victim_way = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim_way = WAY_W'(w);
            end
        end
    end

    assign tgt_way = lk_hit ? hit_way : victim_way;
    assign active  = enable_i && !busy_q;
    assign busy_o  = busy_q;

    // Present the target way's contents while an accepted request is held; zeros otherwise.
    always_comb begin
        hit_o  = 1'b0;
        way_o  = '0;
        tag_o  = '0;
        data_o = '0;
        if (active) begin
            hit_o  = lk_hit;
            way_o  = tgt_way;
            tag_o  = tag_q[addr_i][tgt_way];
            data_o = data_q[addr_i][tgt_way];
        end
    end

    // Storage writes, LRU ageing and the invalidate-all walk.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    data_q[s][w] <= '0;
                    age_q[s][w]  <= WAY_W'(w);
                end
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (active && write_i) begin
                        tag_q[addr_i][tgt_way]  <= tag_i;
                        data_q[addr_i][tgt_way] <= data_i;
                    end
                    // A read miss leaves the ages alone; re-touching the same way is a no-op.
                    if (active && (lk_hit || write_i)) begin
                        for (int w = 0; w < WAYS; w++) begin
                            if (age_q[addr_i][w] < age_q[addr_i][tgt_way]) begin
                                age_q[addr_i][w] <= age_q[addr_i][w] + WAY_W'(1);
                            end
                        end
                        age_q[addr_i][tgt_way] <= '0;
                    end
                    if (inv_i) begin
                        state_q <= WALK;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                WALK: begin
                    // Clear valid/dirty only; address tag and data stay for debug visibility.
                    for (int w = 0; w < WAYS; w++) begin
                        tag_q[cnt_q][w][TAG_W-1:TAG_W-2] <= 2'b00;
                        age_q[cnt_q][w]                  <= WAY_W'(w);
                    end
                    if (cnt_q == IDX_W'(SETS - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
